// File: rtl/alu_pipe_fu.sv
// Pipelined integer ALU functional unit with valid/ready on both sides, tag carry,
// illegal-op detection and flush. The result is computed before stage 0; later stages only carry it.
module alu_pipe_fu #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_alusrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_sign,
    output logic             out_illegal
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLTU = 4'b1000,
        OP_SRA  = 4'b1110
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0]  result;
        logic [TAG_W-1:0] tag;
        logic             zero;
        logic             sign;
        logic             illegal;
    } stage_t;

    stage_t            stage_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] move;
    logic [STAGES-1:0] load;
    logic              chain;
    logic              accept;
    logic [XLEN-1:0]   op_b;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   alu_res;
    logic              alu_ill;
    stage_t            alu_out;

    // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
    always_comb begin
        op_b    = in_alusrc ? in_imm : in_rs2;
        shamt   = op_b[SHW-1:0];
        alu_res = in_rs1;
        alu_ill = 1'b0;
        case (in_op)
            OP_AND:  alu_res = in_rs1 & op_b;
            OP_OR:   alu_res = in_rs1 | op_b;
            OP_ADD:  alu_res = in_rs1 + op_b;
            OP_XOR:  alu_res = in_rs1 ^ op_b;
            OP_SLL:  alu_res = in_rs1 << shamt;
            OP_SRL:  alu_res = in_rs1 >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(in_rs1) >>> shamt);
            OP_SUB:  alu_res = in_rs1 - op_b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(in_rs1) < $signed(op_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, in_rs1 < op_b};
            default: alu_ill = 1'b1;
        endcase
        alu_out.result  = alu_res;
        alu_out.tag     = in_tag;
        alu_out.zero    = (alu_res == '0);
        alu_out.sign    = alu_res[XLEN-1];
        alu_out.illegal = alu_ill;
    end

    // NOTE: 'chain' is a blocking temporary reused down the loop; it carries move[i+1] into stage i.
    always_comb begin
        chain            = valid_q[STAGES-1] && out_ready;
        move[STAGES-1]   = chain;
        for (int i = STAGES - 2; i >= 0; i--) begin
            chain   = valid_q[i] && (!valid_q[i+1] || chain);
            move[i] = chain;
        end
    end

    // Empty stages always load, so bubbles collapse toward the output.
    assign load     = ~valid_q | move;
    assign in_ready = !flush && load[0];
    assign accept   = in_valid && in_ready;

    // NOTE: the data registers are reset too, because the outputs come straight from the last stage
    // and must read zero during reset; flush only clears the valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            if (load[0]) begin
                valid_q[0] <= accept;
                stage_q[0] <= alu_out;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (load[i]) begin
                    valid_q[i] <= move[i-1];
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end
    end

    assign out_valid   = valid_q[STAGES-1];
    assign out_result  = stage_q[STAGES-1].result;
    assign out_tag     = stage_q[STAGES-1].tag;
    assign out_zero    = stage_q[STAGES-1].zero;
    assign out_sign    = stage_q[STAGES-1].sign;
    assign out_illegal = stage_q[STAGES-1].illegal;

endmodule

// File: tb/tb_alu_pipe_fu.sv
// Self-checking bench for alu_pipe_fu: a scoreboard model of in-flight ops checked every cycle,
// plus directed cases with hand-computed results, stall, flush and asynchronous reset.
module tb_alu_pipe_fu;

    localparam int XLEN   = 32;
    localparam int TAG_W  = 6;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_op = '0;
    logic [XLEN-1:0]  in_rs1 = '0;
    logic [XLEN-1:0]  in_rs2 = '0;
    logic [XLEN-1:0]  in_imm = '0;
    logic             in_alusrc = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_sign;
    logic             out_illegal;

    alu_pipe_fu #(.XLEN(XLEN), .TAG_W(TAG_W), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_alusrc(in_alusrc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
        .out_zero(out_zero), .out_sign(out_sign), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU written directly from the op-code table.
    function automatic logic [XLEN-1:0] alu_model(input logic [3:0] op, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b, output logic ill);
        int unsigned sh;
        sh  = b % XLEN;
        ill = 1'b0;
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a ^ b;
            4'b0100: return a << sh;
            4'b0101: return a >> sh;
            4'b1110: return $signed(a) >>> sh;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 1 : 0;
            4'b1000: return (a < b) ? 1 : 0;
            default: begin
                ill = 1'b1;
                return a;
            end
        endcase
    endfunction

    typedef struct {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
        logic             ill;
        int               due;
    } item_t;

    item_t            sb[$];
    logic [TAG_W-1:0] seen_tags[$];
    int               cyc = 0;
    item_t            it;
    logic             ill_m;
    logic             exp_v;
    logic             exp_r;

    // Ops in flight, in issue order. An op shows at the output STAGES cycles after acceptance,
    // or one cycle after its predecessor leaves, whichever is later.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            cyc++;
            exp_v = (sb.size() > 0) && (cyc >= sb[0].due);
            exp_r = !flush && !((sb.size() == STAGES) && !out_ready);
            check("out_valid", out_valid, exp_v);
            check("in_ready", in_ready, exp_r);
            if (out_valid && exp_v) begin
                check("out_result", out_result, sb[0].res);
                check("out_tag", out_tag, sb[0].tag);
                check("out_zero", out_zero, sb[0].res == '0);
                check("out_sign", out_sign, sb[0].res[XLEN-1]);
                check("out_illegal", out_illegal, sb[0].ill);
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready && sb.size() > 0) begin
                    seen_tags.push_back(out_tag);
                    void'(sb.pop_front());
                    if (sb.size() > 0 && sb[0].due < cyc + 1) sb[0].due = cyc + 1;
                end
                if (in_valid && in_ready) begin
                    it.res = alu_model(in_op, in_rs1, in_alusrc ? in_imm : in_rs2, ill_m);
                    it.ill = ill_m;
                    it.tag = in_tag;
                    it.due = cyc + STAGES;
                    sb.push_back(it);
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] rs2,
                        input logic [XLEN-1:0] imm, input logic src, input logic [TAG_W-1:0] tag);
        int n;
        n         = 0;
        in_op     = op;
        in_rs1    = a;
        in_rs2    = rs2;
        in_imm    = imm;
        in_alusrc = src;
        in_tag    = tag;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Single op through an idle pipe with out_ready=1: checks latency and literal results.
    task automatic run_one(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] rs2,
                           input logic [XLEN-1:0] imm, input logic src, input logic [TAG_W-1:0] tag,
                           input logic [XLEN-1:0] e_res, input logic e_zero, input logic e_sign,
                           input logic e_ill);
        send(op, a, rs2, imm, src, tag);
        in_valid = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            check("lat_early", out_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        check("lat_valid", out_valid, 1'b1);
        check("d_result", out_result, e_res);
        check("d_tag", out_tag, tag);
        check("d_zero", out_zero, e_zero);
        check("d_sign", out_sign, e_sign);
        check("d_illegal", out_illegal, e_ill);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XLEN-1:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(XLEN-1){1'b0}}};
            3:       return XLEN'($urandom_range(0, 40));
            default: return XLEN'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, '0);
        check("rst_out_tag", out_tag, '0);
        check("rst_out_flags", {out_zero, out_sign, out_illegal}, 3'b000);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // Directed ops with hand-computed results
        run_one(4'b0010, 32'd5, 32'd7, 32'd0, 1'b0, 6'd3, 32'd12, 1'b0, 1'b0, 1'b0);
        run_one(4'b0110, 32'd1, 32'd2, 32'd0, 1'b0, 6'd4, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_one(4'b0011, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd0, 1'b0, 6'd5, 32'd0, 1'b1, 1'b0, 1'b0);
        run_one(4'b1110, 32'h8000_0000, 32'd1, 32'h24, 1'b1, 6'd6, 32'hF800_0000, 1'b0, 1'b1, 1'b0);
        run_one(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 6'd7, 32'd1, 1'b0, 1'b0, 1'b0);
        run_one(4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 6'd8, 32'd0, 1'b1, 1'b0, 1'b0);
        run_one(4'b0100, 32'h0000_0003, 32'h0000_0101, 32'd0, 1'b0, 6'd9, 32'h0000_0006, 1'b0, 1'b0, 1'b0);
        run_one(4'b1010, 32'h0000_1234, 32'd9, 32'd0, 1'b0, 6'd10, 32'h0000_1234, 1'b0, 1'b0, 1'b1);

        // Eight back-to-back ADDs with a four-cycle stall at the output
        seen_tags.delete();
        fork
            begin
                for (int t = 0; t < 8; t++) send(4'b0010, XLEN'(t * 3 + 1), 32'd100, 32'd0, 1'b0, TAG_W'(t));
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                #1;
                for (int k = 0; k < 4; k++) begin
                    check("stall_in_ready", in_ready, 1'b0);
                    check("stall_out_valid", out_valid, 1'b1);
                    check("stall_out_tag", out_tag, 6'd1);
                    check("stall_out_result", out_result, 32'd104);
                    if (k < 3) begin
                        @(posedge clk);
                        #2;
                    end
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
        #1;
        check("stream_count", seen_tags.size(), 8);
        for (int t = 0; t < 8 && t < seen_tags.size(); t++) check("stream_order", seen_tags[t], TAG_W'(t));

        // Flush with two ops in flight
        out_ready = 1'b0;
        seen_tags.delete();
        send(4'b0001, 32'h10, 32'h1, 32'd0, 1'b0, 6'd20);
        send(4'b0001, 32'h20, 32'h2, 32'd0, 1'b0, 6'd21);
        in_valid = 1'b0;
        flush = 1'b1;
        out_ready = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("post_flush_valid", out_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        check("flush_no_tags", seen_tags.size(), 0);
        run_one(4'b0101, 32'hF000_0000, 32'd0, 32'h3C, 1'b1, 6'd22, 32'h0000_000F, 1'b0, 1'b0, 1'b0);

        // Randomised traffic with backpressure and occasional flush
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_op     = 4'($urandom);
            in_rs1    = rand_val();
            in_rs2    = rand_val();
            in_imm    = rand_val();
            in_alusrc = 1'($urandom);
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 3);
            @(posedge clk);
            #1;
        end
        flush = 1'b0;

        // Asynchronous reset while the pipe is full and stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 4'b0010;
        in_rs1    = 32'h55;
        in_alusrc = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_valid", out_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_result", out_result, '0);
        check("async_rst_in_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_pipe_fu.md
Name: alu_pipe_fu

Overview:
- Parametrised pipelined integer ALU functional unit for the out-of-order back end. It sits between an issue queue and the writeback/CDB arbiter.
- Generalises the single-cycle registered ALU in four ways: configurable data width, configurable pipeline depth, valid/ready handshakes on both sides, and a destination tag carried alongside each result.
- Adds shift-left, logical shift-right and signed/unsigned set-less-than, plus an illegal-op flag and a pipeline flush.
- Zero/sign flags are derived from the true XLEN-bit result.

Parameters:
- XLEN, 32, operand/result width; power of two, 8..64.
- TAG_W, 6, width of the ROB/physical-register tag carried with each op.
- STAGES, 2, pipeline depth in register stages; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all in-flight ops.
- in_valid  in  1  issue side presents an op.
- in_ready  out  1  unit accepts the op this cycle.
- in_op  in  4  ALU control code.
- in_rs1  in  XLEN  operand A.
- in_rs2  in  XLEN  operand B (register).
- in_imm  in  XLEN  operand B (immediate).
- in_alusrc  in  1  1 selects in_imm as B, 0 selects in_rs2.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts the result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.
- out_zero  out  1  result == 0.
- out_sign  out  1  result[XLEN-1].
- out_illegal  out  1  op code was not a defined encoding.

Behaviour:
- Reset (rst_n low, asynchronous): every stage valid bit is 0; out_valid=0; out_result, out_tag, out_zero, out_sign and out_illegal are 0. in_ready=1 from the first edge after reset is released.
- Accept: an op is accepted when in_valid && in_ready on a rising edge. Operands and tag are sampled on that edge.
- Operand B = in_alusrc ? in_imm : in_rs2.
- The result is computed combinationally and registered into stage 0; stages 1..STAGES-1 only carry data.
- Op codes:
  - 0000 AND; 0001 OR; 0010 ADD (mod 2^XLEN); 0011 XOR.
  - 0100 SLL; 0101 SRL; 1110 SRA (arithmetic).
  - 0110 SUB (mod 2^XLEN).
  - 0111 SLT (signed compare, result 1 or 0); 1000 SLTU (unsigned compare).
- Shift amount = B[$clog2(XLEN)-1:0]; upper bits of B are ignored.
- Undefined codes: result = A, illegal=1, zero and sign computed from A like any other result.
- Flags: zero = (result == 0) and sign = result[XLEN-1], for every op. SLT/SLTU results therefore always give sign=0.
- Pipeline control, per stage i:
  - move[i] = v[i] && (i is last ? out_ready : (!v[i+1] || move[i+1])).
  - A stage loads when it is empty or moving; bubbles collapse.
  - in_ready = !flush && (!v[0] || move[0]).
- Latency: exactly STAGES cycles from the accept edge to out_valid, when no stall occurs.
- Throughput: 1 op per cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, all out_* signals hold stable. Upstream stages keep filling until full, then in_ready drops.
- Full condition: all STAGES valid bits set and out_ready=0, which forces in_ready=0.
- Flush: on the edge where flush=1, all valid bits clear and no op is accepted. out_valid=0 in the next cycle. Data registers may retain stale values.
- Flush and reset both override any simultaneous in_valid or out_ready.
- Tag ordering: outputs leave in strict issue order; tags are never reordered or duplicated.

Test Plan:
- Reset, then XLEN=32, STAGES=2. ADD rs1=5, rs2=7, tag=3 with out_ready=1 -> out_valid exactly 2 cycles later with result=12, tag=3, zero=0, sign=0.
- SUB rs1=1, rs2=2 -> result=0xFFFFFFFF, sign=1, zero=0. Then XOR A=B=0xA5A5A5A5 -> result=0, zero=1.
- SRA A=0x80000000, imm=0x24 (alusrc=1) -> shift amount 4, result=0xF8000000. SLT A=-1, B=1 -> 1. SLTU A=-1, B=1 -> 0.
- Back-to-back stream of 8 ADDs with tags 0..7; hold out_ready=0 for cycles 3..6 -> in_ready drops once 2 ops are held. out_* stay stable while stalled. All tags 0..7 appear in order with no loss or duplication.
- Two ops in flight, assert flush for 1 cycle -> out_valid=0 the following cycle, neither tag emerges, and in_ready=0 during the flush cycle.
- Op code 1010 with A=0x1234 -> result=0x1234, illegal=1. Deasserting rst_n mid-stream clears out_valid at once, without waiting for a clock edge.
